// File: rtl/des_pkg.sv
// Shared opcode, ack and state definitions for the DES command controller.
package des_pkg;

  localparam logic [7:0] OP_SET_KEY    = 8'h00;
  localparam logic [7:0] OP_ENC        = 8'h02;
  localparam logic [7:0] OP_DEC        = 8'h03;
  localparam logic [7:0] ACK_KEY_OK    = 8'h00;
  localparam logic [7:0] ACK_ERR_DEF   = 8'hEE;
  localparam logic [7:0] ACK_NOKEY_DEF = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WAIT_DES = 3'd3,
    ST_TX_ACK   = 3'd4,
    ST_TX_DATA  = 3'd5
  } state_e;

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == OP_SET_KEY) || (op == OP_ENC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/des_tx_seq.sv
// Byte-send sequencer: waits for UART ready, pulses start, waits for done,
// repeating for i_Count bytes; o_Idx selects which byte the parent supplies.
module des_tx_seq
  import des_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Go,
  input  logic [3:0] i_Count,
  input  logic [7:0] i_Byte,
  input  logic       i_TxReady,
  input  logic       i_TxDone,
  output logic       o_TxStart,
  output logic [7:0] o_TxData,
  output logic [3:0] o_Idx,
  output logic       o_Done
);

  typedef enum logic [1:0] {
    SQ_IDLE      = 2'd0,
    SQ_WAIT_RDY  = 2'd1,
    SQ_WAIT_DONE = 2'd2
  } seq_e;

  seq_e       seq_reg;
  logic [3:0] count_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      seq_reg   <= SQ_IDLE;
      count_reg <= 4'd0;
      o_TxStart <= 1'b0;
      o_TxData  <= 8'd0;
      o_Idx     <= 4'd0;
      o_Done    <= 1'b0;
    end else begin
      o_TxStart <= 1'b0;
      o_Done    <= 1'b0;
      case (seq_reg)
        SQ_IDLE: begin
          if (i_Go) begin
            o_Idx     <= 4'd0;
            count_reg <= i_Count;
            seq_reg   <= SQ_WAIT_RDY;
          end
        end
        SQ_WAIT_RDY: begin
          if (i_TxReady) begin
            o_TxStart <= 1'b1;
            o_TxData  <= i_Byte;
            seq_reg   <= SQ_WAIT_DONE;
          end
        end
        SQ_WAIT_DONE: begin
          // Done pulses arriving in any other state are stray and ignored.
          if (i_TxDone) begin
            if (o_Idx == count_reg - 4'd1) begin
              o_Done  <= 1'b1;
              o_Idx   <= 4'd0;
              seq_reg <= SQ_IDLE;
            end else begin
              o_Idx   <= o_Idx + 4'd1;
              seq_reg <= SQ_WAIT_RDY;
            end
          end
        end
        default: seq_reg <= SQ_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/des_cmd_ctrl.sv
// Host command framer: collects opcode + 8 payload bytes, drives the DES core,
// and returns an ack byte plus 8 result bytes for encrypt/decrypt.
module des_cmd_ctrl
  import des_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK_ERR     = ACK_ERR_DEF,
  parameter logic [7:0] ACK_NOKEY   = ACK_NOKEY_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_RxDone,
  input  logic [7:0]  i_RxData,
  input  logic        i_TxReady,
  input  logic        i_TxDone,
  output logic        o_TxStart,
  output logic [7:0]  o_TxData,
  output logic        o_KeyLoad,
  output logic        o_DesStart,
  output logic        o_DesDec,
  output logic [63:0] o_Block,
  input  logic        i_DesDone,
  input  logic [63:0] i_DesOut,
  output logic [7:0]  o_LED
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_reg;
  logic [7:0]       opcode_reg;
  logic [2:0]       byte_cnt_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [7:0]       ack_reg;
  logic [63:0]      result_reg;
  logic             has_result_reg;
  logic             key_valid_reg;
  logic             err_sticky_reg;
  logic             tx_go_reg;

  logic [3:0]       tx_idx;
  logic             tx_done;
  logic [7:0]       tx_byte;

  // Index 0 is the ack byte, 1..8 walk the result from its top byte down.
  always_comb begin
    tx_byte = ack_reg;
    for (int i = 1; i <= 8; i++) begin
      if (tx_idx == 4'(i)) tx_byte = result_reg[(8-i)*8 +: 8];
    end
  end

  des_tx_seq u_tx_seq (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_Go      (tx_go_reg),
    .i_Count   (has_result_reg ? 4'd9 : 4'd1),
    .i_Byte    (tx_byte),
    .i_TxReady (i_TxReady),
    .i_TxDone  (i_TxDone),
    .o_TxStart (o_TxStart),
    .o_TxData  (o_TxData),
    .o_Idx     (tx_idx),
    .o_Done    (tx_done)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= ST_IDLE;
      opcode_reg     <= 8'd0;
      byte_cnt_reg   <= 3'd0;
      tmo_cnt_reg    <= '0;
      ack_reg        <= 8'd0;
      result_reg     <= 64'd0;
      has_result_reg <= 1'b0;
      key_valid_reg  <= 1'b0;
      err_sticky_reg <= 1'b0;
      tx_go_reg      <= 1'b0;
      o_KeyLoad      <= 1'b0;
      o_DesStart     <= 1'b0;
      o_DesDec       <= 1'b0;
      o_Block        <= 64'd0;
    end else begin
      o_KeyLoad  <= 1'b0;
      o_DesStart <= 1'b0;
      tx_go_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_RxDone) begin
            if (is_valid_op(i_RxData)) begin
              opcode_reg   <= i_RxData;
              o_Block      <= 64'd0;
              byte_cnt_reg <= 3'd0;
              tmo_cnt_reg  <= '0;
              state_reg    <= ST_COLLECT;
            end else begin
              ack_reg        <= ACK_ERR;
              err_sticky_reg <= 1'b1;
              has_result_reg <= 1'b0;
              tx_go_reg      <= 1'b1;
              state_reg      <= ST_TX_ACK;
            end
          end
        end
        ST_COLLECT: begin
          // A byte landing on the terminal count still wins.
          if (i_RxDone) begin
            o_Block      <= {o_Block[55:0], i_RxData};
            byte_cnt_reg <= byte_cnt_reg + 3'd1;
            tmo_cnt_reg  <= '0;
            if (byte_cnt_reg == 3'd7) state_reg <= ST_EXEC;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            o_Block        <= 64'd0;
            ack_reg        <= ACK_ERR;
            err_sticky_reg <= 1'b1;
            has_result_reg <= 1'b0;
            tx_go_reg      <= 1'b1;
            state_reg      <= ST_TX_ACK;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_EXEC: begin
          if (opcode_reg == OP_SET_KEY) begin
            o_KeyLoad      <= 1'b1;
            key_valid_reg  <= 1'b1;
            ack_reg        <= ACK_KEY_OK;
            has_result_reg <= 1'b0;
            tx_go_reg      <= 1'b1;
            state_reg      <= ST_TX_ACK;
          end else if (!key_valid_reg) begin
            ack_reg        <= ACK_NOKEY;
            err_sticky_reg <= 1'b1;
            has_result_reg <= 1'b0;
            tx_go_reg      <= 1'b1;
            state_reg      <= ST_TX_ACK;
          end else begin
            o_DesStart <= 1'b1;
            o_DesDec   <= opcode_reg[0];
            state_reg  <= ST_WAIT_DES;
          end
        end
        ST_WAIT_DES: begin
          if (i_DesDone) begin
            result_reg     <= i_DesOut;
            ack_reg        <= opcode_reg;
            has_result_reg <= 1'b1;
            tx_go_reg      <= 1'b1;
            state_reg      <= ST_TX_ACK;
          end
        end
        ST_TX_ACK: begin
          if (tx_done)            state_reg <= ST_IDLE;
          else if (tx_idx != 4'd0) state_reg <= ST_TX_DATA;
        end
        ST_TX_DATA: begin
          if (tx_done) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_LED = {key_valid_reg, err_sticky_reg, 3'b000, state_reg};

endmodule

// File: tb/tb_des_cmd_ctrl.sv
// Randomized bench for des_cmd_ctrl with behavioural UART/DES stand-ins and a
// frame-level reference model of the expected host replies.
module tb_des_cmd_ctrl;

  localparam int TMO = 200;
  localparam logic [63:0] KAT_KEY = 64'h1020304050607080;
  localparam logic [63:0] KAT_PT  = 64'h0102030405060708;
  localparam logic [63:0] KAT_CT  = 64'h83D8AFEF97D1D369;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        i_RxDone = 1'b0;
  logic [7:0]  i_RxData = 8'd0;
  logic        i_TxReady = 1'b1;
  logic        i_TxDone = 1'b0;
  logic        i_DesDone = 1'b0;
  logic [63:0] i_DesOut = 64'd0;
  logic        o_TxStart, o_KeyLoad, o_DesStart, o_DesDec;
  logic [7:0]  o_TxData, o_LED;
  logic [63:0] o_Block;

  des_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .i_RxDone(i_RxDone), .i_RxData(i_RxData),
    .i_TxReady(i_TxReady), .i_TxDone(i_TxDone), .o_TxStart(o_TxStart),
    .o_TxData(o_TxData), .o_KeyLoad(o_KeyLoad), .o_DesStart(o_DesStart),
    .o_DesDec(o_DesDec), .o_Block(o_Block), .i_DesDone(i_DesDone),
    .i_DesOut(i_DesOut), .o_LED(o_LED)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in DES core: the known-answer pair, otherwise an arbitrary keyed mix.
  function automatic logic [63:0] core_f(input logic [63:0] key, input logic [63:0] blk, input logic dec);
    if (key == KAT_KEY && !dec && blk == KAT_PT) return KAT_CT;
    if (key == KAT_KEY && dec && blk == KAT_CT) return KAT_PT;
    return {blk[31:0], blk[63:32]} ^ key ^ (dec ? 64'hFFFF0000FFFF0000 : 64'h0F0F0F0F0F0F0F0F);
  endfunction

  // UART_TX and DES core behaviour, plus observation of strobes.
  logic [7:0]  host_q[$];
  bit          tx_busy = 0;
  int          tx_cnt = 0;
  logic [7:0]  tx_byte = 8'd0;
  logic [63:0] core_key = 64'd0, core_in = 64'd0;
  logic        core_dec = 1'b0;
  bit          des_busy = 0;
  int          des_cnt = 0;
  int          kl_cnt = 0, kl_cyc = 0, ds_cnt = 0, ds_cyc = 0;
  logic [63:0] kl_blk = 64'd0, ds_blk = 64'd0;
  logic        ds_dec = 1'b0;

  always @(negedge Clk) begin
    i_TxDone  = 1'b0;
    i_DesDone = 1'b0;
    if (o_TxStart) begin
      check_val("start_rdy", {63'd0, i_TxReady}, 64'd1);
      tx_busy   = 1;
      i_TxReady = 1'b0;
      tx_cnt    = int'($urandom_range(3, 8));
      tx_byte   = o_TxData;
      host_q.push_back(o_TxData);
    end else if (tx_busy) begin
      check_val("txdata_hold", {56'd0, o_TxData}, {56'd0, tx_byte});
      tx_cnt--;
      if (tx_cnt == 0) begin
        i_TxDone  = 1'b1;
        i_TxReady = 1'b1;
        tx_busy   = 0;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      i_TxDone = 1'b1;
    end

    if (o_KeyLoad) begin
      kl_cnt++;
      kl_cyc   = cyc;
      kl_blk   = o_Block;
      core_key = o_Block;
    end
    if (o_DesStart) begin
      ds_cnt++;
      ds_cyc   = cyc;
      ds_blk   = o_Block;
      ds_dec   = o_DesDec;
      core_in  = o_Block;
      core_dec = o_DesDec;
      des_busy = 1;
      des_cnt  = int'($urandom_range(3, 12));
    end else if (des_busy) begin
      des_cnt--;
      if (des_cnt == 0) begin
        i_DesDone = 1'b1;
        i_DesOut  = core_f(core_key, core_in, core_dec);
        des_busy  = 0;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      i_DesDone = 1'b1;
      i_DesOut  = {$urandom, $urandom};
    end
  end

  // Reference model state.
  bit          kv_m = 0;
  bit          err_m = 0;
  logic [63:0] key_m = 64'd0;
  int          rx_cyc = 0;

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge Clk);
    i_RxDone = 1'b1;
    i_RxData = b;
    rx_cyc   = cyc;
    @(negedge Clk);
    i_RxDone = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge Clk);
  endtask

  function automatic int rand_gap();
    if ($urandom_range(0, 9) == 0) return TMO - 20;
    return int'($urandom_range(0, 4));
  endfunction

  function automatic bit valid_op(input logic [7:0] op);
    return op == 8'h00 || op == 8'h02 || op == 8'h03;
  endfunction

  task automatic run_cmd(input logic [7:0] op, input logic [63:0] pl, input int nsend, input bit junk);
    logic [7:0]  expq[$];
    logic [63:0] res;
    logic [7:0]  b;
    int          kl0, ds0, last_cyc, n;
    bit          exp_kl, exp_ds;
    exp_kl = 0;
    exp_ds = 0;
    host_q.delete();
    kl0 = kl_cnt;
    ds0 = ds_cnt;
    send_byte(op, (junk && nsend == 0) ? 0 : rand_gap());
    for (int i = 0; i < nsend; i++) begin
      b = 8'(pl >> (56 - 8 * i));
      send_byte(b, (junk && i == nsend - 1) ? 0 : rand_gap());
    end
    last_cyc = rx_cyc;
    if (junk) send_byte(8'($urandom), 0);

    if (!valid_op(op) || nsend < 8) begin
      expq.push_back(8'hEE);
      err_m = 1;
    end else if (op == 8'h00) begin
      expq.push_back(8'h00);
      key_m  = pl;
      kv_m   = 1;
      exp_kl = 1;
    end else if (!kv_m) begin
      expq.push_back(8'hEF);
      err_m = 1;
    end else begin
      exp_ds = 1;
      res = core_f(key_m, pl, op[0]);
      expq.push_back(op);
      for (int i = 0; i < 8; i++) expq.push_back(8'(res >> (56 - 8 * i)));
    end

    for (int w = 0; w < 4000; w++) begin
      @(negedge Clk);
      if (host_q.size() >= expq.size() && o_LED[2:0] == 3'd0 && !tx_busy) break;
    end
    repeat (2) @(negedge Clk);

    n = host_q.size();
    check_val("nbytes", 64'(n), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      check_val($sformatf("byte%0d", i), (i < n) ? {56'd0, host_q[i]} : 64'hFFFF, {56'd0, expq[i]});
    check_val("keyload_n", 64'(kl_cnt - kl0), {63'd0, exp_kl});
    if (exp_kl && kl_cnt > kl0) begin
      check_val("key_block", kl_blk, pl);
      check_val("key_lat", 64'(kl_cyc - last_cyc), 64'd2);
    end
    check_val("desstart_n", 64'(ds_cnt - ds0), {63'd0, exp_ds});
    if (exp_ds && ds_cnt > ds0) begin
      check_val("des_block", ds_blk, pl);
      check_val("des_dec", {63'd0, ds_dec}, {63'd0, op[0]});
      check_val("des_lat", 64'(ds_cyc - last_cyc), 64'd2);
    end
    check_val("led", {56'd0, o_LED}, {56'd0, kv_m, err_m, 6'd0});
    $display("cmd op=%h sent=%0d junk=%0d ack=%h nbytes=%0d led=%h", op, nsend, junk,
             (n > 0) ? host_q[0] : 8'hxx, n, o_LED);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_txstart"}, {63'd0, o_TxStart}, 64'd0);
    check_val({tag, "_txdata"}, {56'd0, o_TxData}, 64'd0);
    check_val({tag, "_keyload"}, {63'd0, o_KeyLoad}, 64'd0);
    check_val({tag, "_desstart"}, {63'd0, o_DesStart}, 64'd0);
    check_val({tag, "_desdec"}, {63'd0, o_DesDec}, 64'd0);
    check_val({tag, "_block"}, o_Block, 64'd0);
    check_val({tag, "_led"}, {56'd0, o_LED}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [63:0] pl;
    int          r, ns;
    repeat (3) @(negedge Clk);
    check_outputs_zero("reset");
    Rst = 1'b0;

    run_cmd(8'h02, KAT_PT, 8, 0);
    run_cmd(8'h5A, 64'd0, 0, 0);
    run_cmd(8'h00, KAT_KEY, 3, 0);
    run_cmd(8'h00, KAT_KEY, 8, 0);
    run_cmd(8'h02, KAT_PT, 8, 1);
    run_cmd(8'h03, KAT_CT, 8, 0);

    for (int k = 0; k < 24; k++) begin
      r  = int'($urandom_range(0, 99));
      pl = {$urandom, $urandom};
      ns = 8;
      if (r < 25) op = 8'h00;
      else if (r < 75) op = ($urandom_range(0, 1) == 1) ? 8'h03 : 8'h02;
      else if (r < 87) begin
        op = 8'($urandom);
        while (valid_op(op)) op = 8'($urandom);
        ns = 0;
      end else begin
        op = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'h02;
        ns = int'($urandom_range(0, 7));
      end
      run_cmd(op, pl, ns, (ns == 0 || ns == 8) && $urandom_range(0, 1) == 1);
    end

    run_cmd(8'h00, KAT_KEY, 8, 0);
    send_byte(8'h02, 1);
    for (int i = 0; i < 4; i++) send_byte(8'(KAT_PT >> (56 - 8 * i)), 1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check_outputs_zero("midrst");
    Rst = 1'b0;
    kv_m  = 0;
    err_m = 0;
    $display("cmd reset mid-frame led=%h", o_LED);
    run_cmd(8'h00, KAT_KEY, 8, 0);
    run_cmd(8'h02, KAT_PT, 8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
